hssl_cfg_bank: RTL and testbench
================================

HSSL_CFG_BANK -- requirements
Module: hssl_cfg_bank

Interface
REQ-001 NUM_HREGS, 1, number of HSSL control registers (1..16).
REQ-002 NUM_RREGS, 16, number of routing key/mask/route triples (1..16).
REQ-003 NUM_CREGS, 2, number of diagnostic counters (1..16).
REQ-004 NUM_MREGS, 4, number of mapper mask/shift pairs (1..16).
REQ-005 CTR_SAT, 1, counter overflow: 1 saturates at 32'hffff_ffff, 0 wraps to 0.
REQ-006 CTR_COR, 0, 1 clears a counter when it is read over APB.
REQ-007 clk  in  1  sole clock, all state on rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 apb_psel_in  in  1  APB select.
REQ-010 apb_penable_in  in  1  APB access phase.
REQ-011 apb_pwrite_in  in  1  APB write (1) / read (0).
REQ-012 apb_paddr_in  in  40  APB byte address.
REQ-013 apb_pwdata_in  in  32  APB write data.
REQ-014 apb_prdata_out  out  32  APB read data, valid with pready.
REQ-015 apb_pready_out  out  1  APB transfer complete, one-cycle pulse.
REQ-016 apb_pslverr_out  out  1  APB error, valid with pready.
REQ-017 prx_vld_in  in  1  packet access request.
REQ-018 prx_wr_in  in  1  packet access is write (1) / read (0).
REQ-019 prx_addr_in  in  8  packet word address.
REQ-020 prx_data_in  in  32  packet write data.
REQ-021 prx_rdy_out  out  1  packet access accepted when prx_vld_in && prx_rdy_out.
REQ-022 rsp_vld_out  out  1  packet read response valid, held until rsp_rdy_in.
REQ-023 rsp_data_out  out  32  packet read response data.
REQ-024 rsp_rdy_in  in  1  response consumer ready.
REQ-025 ctr_cnt_in  in  NUM_CREGS  per-counter increment strobes.
REQ-026 reg_hssl_out  out  1 x NUM_HREGS  HSSL control bits.
REQ-027 reg_key_out  out  32 x NUM_RREGS  routing keys.
REQ-028 reg_mask_out  out  32 x NUM_RREGS  routing masks.
REQ-029 reg_route_out  out  3 x NUM_RREGS  routes.
REQ-030 reg_mpmsk_out  out  32 x NUM_MREGS  mapper masks.
REQ-031 reg_mpsft_out  out  5 x NUM_MREGS  mapper shifts.

Function
REQ-032 Address decode: section = APB addr[8:6] / packet addr[6:4], index = APB addr[5:2] / packet addr[3:0]; sections 0 H, 1 K, 2 M, 3 R, 4 C, 5 A, 6 S; section 7 or index >= section size is out-of-range.
REQ-033 Writes truncate to register width (LSBs kept); reads zero-extend; out-of-range writes have no effect, out-of-range reads return 32'hdead_beef.
REQ-034 APB FSM IDLE->ACCESS on psel&&penable; in ACCESS, if no accepted packet access that cycle, performs the read/write and goes to DONE, else stays in ACCESS (stall).
REQ-035 DONE: pready=1 for exactly one cycle with prdata/pslverr valid, then IDLE; minimum latency = pready in 2nd cycle after penable rises.
REQ-036 apb_pslverr_out=1 in DONE iff the address was out-of-range; 0 otherwise.
REQ-037 Packet accesses have priority and are never stalled by APB; prx_rdy_out = !rsp_vld_out || rsp_rdy_in.
REQ-038 Accepted packet write updates target on the next edge; accepted packet read loads rsp_data_out and sets rsp_vld_out on the next edge.
REQ-039 rsp_vld_out clears on rsp_vld_out&&rsp_rdy_in unless a new read is accepted in the same cycle (back-to-back, no bubble).
REQ-040 Counter priority per cycle: packet write > APB write > APB clear-on-read > increment; clear-on-read coincident with increment leaves value 1.
REQ-041 Increment at 32'hffff_ffff: holds if CTR_SAT=1, becomes 0 if CTR_SAT=0.
REQ-042 Packet reads never clear counters; APB reads of section 4 clear only when CTR_COR=1 and index in range.
REQ-043 Register outputs update only via writes; a write and a read of the same register in one cycle return the old value.

Reset
REQ-044 On reset: all registers, counters, apb_prdata_out, apb_pready_out, apb_pslverr_out, rsp_vld_out, rsp_data_out = 0; FSM = IDLE; in-flight APB transfer and pending response are discarded; prx_rdy_out = 1.

Verification
REQ-045 APB write 0x1234_5678 to 0x044 then read 0x044 -> reg_key_out[1]=0x1234_5678, read returns it, pready 2 cycles after penable, pslverr=0.
REQ-046 APB write to 0x030 with NUM_HREGS=1 -> no register change, pslverr=1; read 0x1C0 -> 32'hdead_beef, pslverr=1.
REQ-047 Packet write to 0x31 (route[1]) with data 0xF every cycle during APB write -> APB pready stays 0 until prx_vld_in drops; route[1]=3'h7.
REQ-048 Packet reads of 0x10, 0x11 back-to-back with rsp_rdy_in=0 for 3 cycles -> prx_rdy_out=0 while held; rsp_data_out stable; both responses delivered in order.
REQ-049 Counter preset 0xFFFF_FFFE, ctr_cnt_in=1 for 3 cycles -> ends 0xFFFF_FFFF (CTR_SAT=1) or 0x0000_0001 (CTR_SAT=0).
REQ-050 CTR_COR=1, counter=5, APB read with increment in clearing cycle -> read returns 5, counter becomes 1; reset asserted mid-transfer -> pready never asserts, all outputs 0.

Source files
------------

// File: rtl/hssl_cfg_bank.sv
// HSSL configuration register bank: control, routing, mapper and counter registers
// reachable from an APB slave port and a higher-priority packet access port.
module hssl_cfg_bank #(
    parameter int unsigned NUM_HREGS = 1,
    parameter int unsigned NUM_RREGS = 16,
    parameter int unsigned NUM_CREGS = 2,
    parameter int unsigned NUM_MREGS = 4,
    parameter bit          CTR_SAT   = 1'b1,
    parameter bit          CTR_COR   = 1'b0
) (
    input  logic                        clk,
    input  logic                        reset,

    input  logic                        apb_psel_in,
    input  logic                        apb_penable_in,
    input  logic                        apb_pwrite_in,
    input  logic [39:0]                 apb_paddr_in,
    input  logic [31:0]                 apb_pwdata_in,
    output logic [31:0]                 apb_prdata_out,
    output logic                        apb_pready_out,
    output logic                        apb_pslverr_out,

    input  logic                        prx_vld_in,
    input  logic                        prx_wr_in,
    input  logic [7:0]                  prx_addr_in,
    input  logic [31:0]                 prx_data_in,
    output logic                        prx_rdy_out,
    output logic                        rsp_vld_out,
    output logic [31:0]                 rsp_data_out,
    input  logic                        rsp_rdy_in,

    input  logic [NUM_CREGS-1:0]        ctr_cnt_in,

    output logic [NUM_HREGS-1:0]        reg_hssl_out,
    output logic [NUM_RREGS-1:0][31:0]  reg_key_out,
    output logic [NUM_RREGS-1:0][31:0]  reg_mask_out,
    output logic [NUM_RREGS-1:0][2:0]   reg_route_out,
    output logic [NUM_MREGS-1:0][31:0]  reg_mpmsk_out,
    output logic [NUM_MREGS-1:0][4:0]   reg_mpsft_out
);

    localparam logic [2:0] SecH = 3'd0;
    localparam logic [2:0] SecK = 3'd1;
    localparam logic [2:0] SecM = 3'd2;
    localparam logic [2:0] SecR = 3'd3;
    localparam logic [2:0] SecC = 3'd4;
    localparam logic [2:0] SecA = 3'd5;
    localparam logic [2:0] SecS = 3'd6;

    localparam logic [31:0] OorData = 32'hdead_beef;

    typedef enum logic [1:0] {StIdle, StAccess, StDone} apb_state_e;

    function automatic logic in_range(input logic [2:0] sec, input logic [3:0] idx);
        logic [31:0] idx_w;
        idx_w = {28'd0, idx};
        case (sec)
            SecH:             in_range = idx_w < NUM_HREGS;
            SecK, SecM, SecR: in_range = idx_w < NUM_RREGS;
            SecC:             in_range = idx_w < NUM_CREGS;
            SecA, SecS:       in_range = idx_w < NUM_MREGS;
            default:          in_range = 1'b0;
        endcase
    endfunction

    // Register state
    logic [NUM_HREGS-1:0]       hssl_q;
    logic [NUM_RREGS-1:0][31:0] key_q;
    logic [NUM_RREGS-1:0][31:0] mask_q;
    logic [NUM_RREGS-1:0][2:0]  route_q;
    logic [NUM_CREGS-1:0][31:0] ctr_q;
    logic [NUM_MREGS-1:0][31:0] mpmsk_q;
    logic [NUM_MREGS-1:0][4:0]  mpsft_q;

    // Zero-extended read view of every section, padded to 16 entries
    logic [7:0][15:0][31:0] rd_tab;

    // APB side
    apb_state_e  state_q, state_d;
    logic [31:0] prdata_q;
    logic        pslverr_q;
    logic [2:0]  apb_sec;
    logic [3:0]  apb_idx;
    logic        apb_ok;
    logic        apb_do;
    logic [31:0] apb_rdata;
    logic        cor_en;

    // Packet side
    logic        rsp_vld_q;
    logic [31:0] rsp_data_q;
    logic [2:0]  pkt_sec;
    logic [3:0]  pkt_idx;
    logic        pkt_ok;
    logic        pkt_acc;
    logic [31:0] pkt_rdata;

    // Shared write port
    logic        wr_en;
    logic [2:0]  wr_sec;
    logic [3:0]  wr_idx;
    logic [31:0] wr_data;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{apb_paddr_in[39:9], apb_paddr_in[1:0], prx_addr_in[7]};

    // Decode
    assign apb_sec = apb_paddr_in[8:6];
    assign apb_idx = apb_paddr_in[5:2];
    assign pkt_sec = prx_addr_in[6:4];
    assign pkt_idx = prx_addr_in[3:0];
    assign apb_ok  = in_range(apb_sec, apb_idx);
    assign pkt_ok  = in_range(pkt_sec, pkt_idx);

    assign apb_rdata = apb_ok ? rd_tab[apb_sec][apb_idx] : OorData;
    assign pkt_rdata = pkt_ok ? rd_tab[pkt_sec][pkt_idx] : OorData;

    assign prx_rdy_out = !rsp_vld_q || rsp_rdy_in;
    assign pkt_acc     = prx_vld_in && prx_rdy_out;

    // Any accepted packet access stalls the APB access phase
    assign apb_do = (state_q == StAccess) && !pkt_acc;
    assign cor_en = CTR_COR && apb_do && !apb_pwrite_in && apb_ok && (apb_sec == SecC);

    always_comb begin
        wr_en   = 1'b0;
        wr_sec  = pkt_sec;
        wr_idx  = pkt_idx;
        wr_data = prx_data_in;
        if (pkt_acc && prx_wr_in) begin
            wr_en = pkt_ok;
        end else if (apb_do && apb_pwrite_in) begin
            wr_en   = apb_ok;
            wr_sec  = apb_sec;
            wr_idx  = apb_idx;
            wr_data = apb_pwdata_in;
        end
    end

    // HSSL control bits
    for (genvar i = 0; i < 16; i++) begin : g_h
        if (i < NUM_HREGS) begin : g_reg
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    hssl_q[i] <= 1'b0;
                end else if (wr_en && wr_sec == SecH && wr_idx == 4'(i)) begin
                    hssl_q[i] <= wr_data[0];
                end
            end
            assign rd_tab[SecH][i] = {31'd0, hssl_q[i]};
        end else begin : g_pad
            assign rd_tab[SecH][i] = '0;
        end
    end

    // Routing key/mask/route triples
    for (genvar i = 0; i < 16; i++) begin : g_r
        if (i < NUM_RREGS) begin : g_reg
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    key_q[i]   <= '0;
                    mask_q[i]  <= '0;
                    route_q[i] <= '0;
                end else if (wr_en && wr_idx == 4'(i)) begin
                    case (wr_sec)
                        SecK:    key_q[i]   <= wr_data;
                        SecM:    mask_q[i]  <= wr_data;
                        SecR:    route_q[i] <= wr_data[2:0];
                        default: ;
                    endcase
                end
            end
            assign rd_tab[SecK][i] = key_q[i];
            assign rd_tab[SecM][i] = mask_q[i];
            assign rd_tab[SecR][i] = {29'd0, route_q[i]};
        end else begin : g_pad
            assign rd_tab[SecK][i] = '0;
            assign rd_tab[SecM][i] = '0;
            assign rd_tab[SecR][i] = '0;
        end
    end

    // Mapper mask/shift pairs
    for (genvar i = 0; i < 16; i++) begin : g_m
        if (i < NUM_MREGS) begin : g_reg
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    mpmsk_q[i] <= '0;
                    mpsft_q[i] <= '0;
                end else if (wr_en && wr_idx == 4'(i)) begin
                    case (wr_sec)
                        SecA:    mpmsk_q[i] <= wr_data;
                        SecS:    mpsft_q[i] <= wr_data[4:0];
                        default: ;
                    endcase
                end
            end
            assign rd_tab[SecA][i] = mpmsk_q[i];
            assign rd_tab[SecS][i] = {27'd0, mpsft_q[i]};
        end else begin : g_pad
            assign rd_tab[SecA][i] = '0;
            assign rd_tab[SecS][i] = '0;
        end
    end

    // Diagnostic counters: write > clear-on-read > increment
    for (genvar i = 0; i < 16; i++) begin : g_c
        if (i < NUM_CREGS) begin : g_reg
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    ctr_q[i] <= '0;
                end else if (wr_en && wr_sec == SecC && wr_idx == 4'(i)) begin
                    ctr_q[i] <= wr_data;
                end else if (cor_en && apb_idx == 4'(i)) begin
                    // An increment landing on the clearing cycle is not lost
                    ctr_q[i] <= {31'd0, ctr_cnt_in[i]};
                end else if (ctr_cnt_in[i]) begin
                    if (!(CTR_SAT && (&ctr_q[i]))) begin
                        ctr_q[i] <= ctr_q[i] + 32'd1;
                    end
                end
            end
            assign rd_tab[SecC][i] = ctr_q[i];
        end else begin : g_pad
            assign rd_tab[SecC][i] = '0;
        end
    end

    assign rd_tab[3'd7] = '0;

    // APB transfer FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (apb_psel_in && apb_penable_in) state_d = StAccess;
            StAccess: if (!pkt_acc) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (apb_do) begin
                prdata_q  <= apb_pwrite_in ? 32'd0 : apb_rdata;
                pslverr_q <= !apb_ok;
            end
        end
    end

    // Packet read response; a consumed response is replaced without a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_vld_q  <= 1'b0;
            rsp_data_q <= '0;
        end else if (pkt_acc && !prx_wr_in) begin
            rsp_vld_q  <= 1'b1;
            rsp_data_q <= pkt_rdata;
        end else if (rsp_vld_q && rsp_rdy_in) begin
            rsp_vld_q <= 1'b0;
        end
    end

    assign apb_prdata_out  = prdata_q;
    assign apb_pready_out  = (state_q == StDone);
    assign apb_pslverr_out = pslverr_q;
    assign rsp_vld_out     = rsp_vld_q;
    assign rsp_data_out    = rsp_data_q;

    assign reg_hssl_out  = hssl_q;
    assign reg_key_out   = key_q;
    assign reg_mask_out  = mask_q;
    assign reg_route_out = route_q;
    assign reg_mpmsk_out = mpmsk_q;
    assign reg_mpsft_out = mpsft_q;

endmodule

// File: tb/tb_hssl_cfg_bank.sv
// Bench for hssl_cfg_bank: directed scenarios plus randomized APB/packet traffic
// checked against a section/index array model of the register map.
module tb_hssl_cfg_bank;

    localparam int unsigned NH = 1;
    localparam int unsigned NR = 16;
    localparam int unsigned NC = 2;
    localparam int unsigned NM = 4;
    localparam bit          SAT = 1'b1;
    localparam bit          COR = 1'b1;

    logic               clk;
    logic               reset;
    logic               apb_psel_in, apb_penable_in, apb_pwrite_in;
    logic [39:0]        apb_paddr_in;
    logic [31:0]        apb_pwdata_in, apb_prdata_out;
    logic               apb_pready_out, apb_pslverr_out;
    logic               prx_vld_in, prx_wr_in, prx_rdy_out;
    logic [7:0]         prx_addr_in;
    logic [31:0]        prx_data_in;
    logic               rsp_vld_out, rsp_rdy_in;
    logic [31:0]        rsp_data_out;
    logic [NC-1:0]      ctr_cnt_in;
    logic [NH-1:0]      reg_hssl_out;
    logic [NR-1:0][31:0] reg_key_out, reg_mask_out;
    logic [NR-1:0][2:0] reg_route_out;
    logic [NM-1:0][31:0] reg_mpmsk_out;
    logic [NM-1:0][4:0] reg_mpsft_out;

    hssl_cfg_bank #(
        .NUM_HREGS(NH), .NUM_RREGS(NR), .NUM_CREGS(NC), .NUM_MREGS(NM),
        .CTR_SAT(SAT), .CTR_COR(COR)
    ) dut (
        .clk(clk), .reset(reset),
        .apb_psel_in(apb_psel_in), .apb_penable_in(apb_penable_in),
        .apb_pwrite_in(apb_pwrite_in), .apb_paddr_in(apb_paddr_in),
        .apb_pwdata_in(apb_pwdata_in), .apb_prdata_out(apb_prdata_out),
        .apb_pready_out(apb_pready_out), .apb_pslverr_out(apb_pslverr_out),
        .prx_vld_in(prx_vld_in), .prx_wr_in(prx_wr_in), .prx_addr_in(prx_addr_in),
        .prx_data_in(prx_data_in), .prx_rdy_out(prx_rdy_out),
        .rsp_vld_out(rsp_vld_out), .rsp_data_out(rsp_data_out), .rsp_rdy_in(rsp_rdy_in),
        .ctr_cnt_in(ctr_cnt_in),
        .reg_hssl_out(reg_hssl_out), .reg_key_out(reg_key_out), .reg_mask_out(reg_mask_out),
        .reg_route_out(reg_route_out), .reg_mpmsk_out(reg_mpmsk_out),
        .reg_mpsft_out(reg_mpsft_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: mdl[section][index], values stored already truncated
    logic [31:0] mdl [8][16];

    function automatic int unsigned sec_size(input int s);
        case (s)
            0:       return NH;
            1, 2, 3: return NR;
            4:       return NC;
            5, 6:    return NM;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] sec_mask(input int s);
        case (s)
            0:       return 32'h1;
            3:       return 32'h7;
            6:       return 32'h1f;
            default: return 32'hffff_ffff;
        endcase
    endfunction

    function automatic bit in_rng(input int s, input int i);
        return i < int'(sec_size(s));
    endfunction

    function automatic logic [31:0] mdl_read(input int s, input int i);
        return in_rng(s, i) ? mdl[s][i] : 32'hdead_beef;
    endfunction

    task automatic mdl_write(input int s, input int i, input logic [31:0] d);
        if (in_rng(s, i)) mdl[s][i] = d & sec_mask(s);
    endtask

    task automatic mdl_reset();
        for (int s = 0; s < 8; s++)
            for (int i = 0; i < 16; i++) mdl[s][i] = '0;
    endtask

    function automatic logic [39:0] apb_addr(input int s, input int i);
        return {31'($urandom), 3'(s), 4'(i), 2'($urandom)};
    endfunction

    function automatic logic [7:0] pkt_addr(input int s, input int i);
        return {1'($urandom), 3'(s), 4'(i)};
    endfunction

    task automatic apb_xfer(input logic wr, input logic [39:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int lat);
        @(posedge clk); #1;
        apb_psel_in = 1'b1; apb_penable_in = 1'b0; apb_pwrite_in = wr;
        apb_paddr_in = addr; apb_pwdata_in = wdata;
        @(posedge clk); #1;
        apb_penable_in = 1'b1;
        lat = 0;
        while (1) begin
            @(negedge clk);
            if (apb_pready_out) break;
            lat++;
            if (lat > 40) begin
                checks++; errors++;
                $display("FAIL apb_timeout addr=%h: pready never seen", addr);
                break;
            end
        end
        rdata = apb_prdata_out;
        err = apb_pslverr_out;
        @(posedge clk); #1;
        apb_psel_in = 1'b0; apb_penable_in = 1'b0; apb_pwrite_in = 1'b0;
    endtask

    task automatic pkt_write(input logic [7:0] addr, input logic [31:0] d);
        @(posedge clk); #1;
        rsp_rdy_in = 1'b1; prx_vld_in = 1'b1; prx_wr_in = 1'b1;
        prx_addr_in = addr; prx_data_in = d;
        @(posedge clk); #1;
        prx_vld_in = 1'b0; prx_wr_in = 1'b0;
    endtask

    task automatic pkt_read(input logic [7:0] addr, output logic [31:0] d, output logic v);
        @(posedge clk); #1;
        rsp_rdy_in = 1'b1; prx_vld_in = 1'b1; prx_wr_in = 1'b0; prx_addr_in = addr;
        @(posedge clk); #1;
        prx_vld_in = 1'b0;
        @(negedge clk);
        d = rsp_data_out;
        v = rsp_vld_out;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        apb_psel_in = 0; apb_penable_in = 0; apb_pwrite_in = 0; apb_paddr_in = '0;
        apb_pwdata_in = '0; prx_vld_in = 0; prx_wr_in = 0; prx_addr_in = '0;
        prx_data_in = '0; rsp_rdy_in = 0; ctr_cnt_in = '0;
        mdl_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({apb_pready_out, apb_pslverr_out, rsp_vld_out} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000",
                     {apb_pready_out, apb_pslverr_out, rsp_vld_out});
        end
        checks++;
        if (prx_rdy_out !== 1'b1) begin
            errors++; $display("FAIL reset_prx_rdy: got %b want 1", prx_rdy_out);
        end
        checks++;
        if (apb_prdata_out !== 32'd0 || rsp_data_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: prdata=%h rsp=%h want 0", apb_prdata_out, rsp_data_out);
        end
        checks++;
        if (reg_key_out !== '0 || reg_route_out !== '0 || reg_hssl_out !== '0) begin
            errors++; $display("FAIL reset_regs: key/route/hssl not zero");
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_apb_basic();
        logic [31:0] rd; logic err; int lat;
        apb_xfer(1'b1, 40'h044, 32'h1234_5678, rd, err, lat);
        mdl_write(1, 1, 32'h1234_5678);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL apb_wr_latency: got %0d want 2", lat); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL apb_wr_err: got %b want 0", err); end
        checks++;
        if (reg_key_out[1] !== mdl[1][1]) begin
            errors++; $display("FAIL apb_key1: got %h want %h", reg_key_out[1], mdl[1][1]);
        end
        apb_xfer(1'b0, 40'h044, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'h1234_5678) begin
            errors++; $display("FAIL apb_rd_data: got %h want 12345678", rd);
        end
        checks++;
        if (lat !== 2 || err !== 1'b0) begin
            errors++; $display("FAIL apb_rd_status: lat=%0d err=%b want 2/0", lat, err);
        end
    endtask

    task automatic test_apb_range();
        logic [31:0] rd; logic err; int lat;
        apb_xfer(1'b1, 40'h030, 32'hffff_ffff, rd, err, lat);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL oor_wr_err: got %b want 1", err); end
        checks++;
        if (reg_hssl_out[0] !== mdl[0][0][0]) begin
            errors++; $display("FAIL oor_wr_hssl: got %b want %b", reg_hssl_out[0], mdl[0][0][0]);
        end
        apb_xfer(1'b0, 40'h1c0, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'hdead_beef || err !== 1'b1) begin
            errors++; $display("FAIL oor_rd: got %h/%b want deadbeef/1", rd, err);
        end
    endtask

    task automatic test_stall();
        logic [31:0] w; int n;
        w = $urandom;
        @(posedge clk); #1;
        apb_psel_in = 1; apb_penable_in = 0; apb_pwrite_in = 1;
        apb_paddr_in = apb_addr(1, 2); apb_pwdata_in = w;
        rsp_rdy_in = 1; prx_vld_in = 1; prx_wr_in = 1; prx_addr_in = 8'h31; prx_data_in = 32'hf;
        @(posedge clk); #1;
        apb_penable_in = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (apb_pready_out !== 1'b0) begin
                errors++; $display("FAIL stall_pready cyc%0d: got 1 want 0", k);
            end
        end
        @(posedge clk); #1;
        prx_vld_in = 0; prx_wr_in = 0;
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (apb_pready_out || n > 20) break;
        end
        checks++;
        if (n !== 2) begin errors++; $display("FAIL stall_release: pready after %0d want 2", n); end
        mdl_write(3, 1, 32'hf);
        mdl_write(1, 2, w);
        checks++;
        if (apb_pslverr_out !== 1'b0) begin errors++; $display("FAIL stall_err: got 1 want 0"); end
        checks++;
        if (reg_route_out[1] !== 3'h7) begin
            errors++; $display("FAIL stall_route1: got %h want 7", reg_route_out[1]);
        end
        checks++;
        if (reg_key_out[2] !== mdl[1][2]) begin
            errors++; $display("FAIL stall_key2: got %h want %h", reg_key_out[2], mdl[1][2]);
        end
        @(posedge clk); #1;
        apb_psel_in = 0; apb_penable_in = 0; apb_pwrite_in = 0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] k0, k1;
        k0 = $urandom; k1 = $urandom;
        pkt_write(8'h10, k0); mdl_write(1, 0, k0);
        pkt_write(8'h11, k1); mdl_write(1, 1, k1);
        @(posedge clk); #1;
        rsp_rdy_in = 0; prx_vld_in = 1; prx_wr_in = 0; prx_addr_in = 8'h10;
        @(posedge clk); #1;
        prx_addr_in = 8'h11;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (prx_rdy_out !== 1'b0 || rsp_vld_out !== 1'b1 || rsp_data_out !== mdl[1][0]) begin
                errors++;
                $display("FAIL b2b_hold cyc%0d: rdy=%b vld=%b data=%h want 0/1/%h",
                         k, prx_rdy_out, rsp_vld_out, rsp_data_out, mdl[1][0]);
            end
        end
        @(posedge clk); #1;
        rsp_rdy_in = 1;
        @(negedge clk);
        checks++;
        if (prx_rdy_out !== 1'b1) begin errors++; $display("FAIL b2b_rdy: got 0 want 1"); end
        @(posedge clk); #1;
        prx_vld_in = 0;
        @(negedge clk);
        checks++;
        if (rsp_vld_out !== 1'b1 || rsp_data_out !== mdl[1][1]) begin
            errors++;
            $display("FAIL b2b_second: vld=%b data=%h want 1/%h", rsp_vld_out, rsp_data_out,
                     mdl[1][1]);
        end
        @(negedge clk);
        checks++;
        if (rsp_vld_out !== 1'b0) begin errors++; $display("FAIL b2b_drain: vld=1 want 0"); end
    endtask

    task automatic test_ctr_sat();
        logic [31:0] exp, d; logic v;
        pkt_write(8'h40, 32'hffff_fffe);
        ctr_cnt_in = 2'b01;
        repeat (3) @(posedge clk);
        #1 ctr_cnt_in = '0;
        exp = 32'hffff_fffe;
        for (int k = 0; k < 3; k++) exp = (SAT && exp == 32'hffff_ffff) ? exp : exp + 1;
        mdl[4][0] = exp;
        for (int k = 0; k < 2; k++) begin
            pkt_read(8'h40, d, v);
            checks++;
            if (v !== 1'b1 || d !== mdl[4][0]) begin
                errors++; $display("FAIL ctr_sat rd%0d: got %h (vld %b) want %h", k, d, v, exp);
            end
        end
    endtask

    task automatic test_cor();
        logic [31:0] d; logic v; int n;
        pkt_write(8'h41, 32'd5);
        mdl[4][1] = 32'd5;
        @(posedge clk); #1;
        apb_psel_in = 1; apb_penable_in = 0; apb_pwrite_in = 0; apb_paddr_in = apb_addr(4, 1);
        @(posedge clk); #1;
        apb_penable_in = 1;
        @(posedge clk); #1;
        ctr_cnt_in = 2'b10;
        @(posedge clk); #1;
        ctr_cnt_in = '0;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (apb_pready_out || n > 20) break;
            n++;
        end
        checks++;
        if (apb_prdata_out !== mdl[4][1] || apb_pslverr_out !== 1'b0) begin
            errors++;
            $display("FAIL cor_read: got %h/%b want %h/0", apb_prdata_out, apb_pslverr_out,
                     mdl[4][1]);
        end
        mdl[4][1] = COR ? 32'd1 : mdl[4][1] + 1;
        @(posedge clk); #1;
        apb_psel_in = 0; apb_penable_in = 0;
        pkt_read(8'h41, d, v);
        checks++;
        if (d !== mdl[4][1]) begin errors++; $display("FAIL cor_after: got %h want %h", d, mdl[4][1]); end
    endtask

    task automatic test_random();
        logic [31:0] rd, d; logic err, v; int lat, op, s, i;
        rsp_rdy_in = 1; ctr_cnt_in = '0;
        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 3);
            s = $urandom_range(0, 7);
            if (s == 7 || $urandom_range(0, 3) == 0) i = $urandom_range(0, 15);
            else i = $urandom_range(0, sec_size(s) - 1);
            d = $urandom;
            case (op)
                0: begin
                    apb_xfer(1'b1, apb_addr(s, i), d, rd, err, lat);
                    checks++;
                    if (err !== !in_rng(s, i) || lat !== 2) begin
                        errors++;
                        $display("FAIL rnd_apb_wr s%0d i%0d: err=%b lat=%0d want %b/2",
                                 s, i, err, lat, !in_rng(s, i));
                    end
                    mdl_write(s, i, d);
                end
                1: begin
                    apb_xfer(1'b0, apb_addr(s, i), 32'h0, rd, err, lat);
                    checks++;
                    if (rd !== mdl_read(s, i) || err !== !in_rng(s, i)) begin
                        errors++;
                        $display("FAIL rnd_apb_rd s%0d i%0d: got %h/%b want %h/%b",
                                 s, i, rd, err, mdl_read(s, i), !in_rng(s, i));
                    end
                    if (COR && s == 4 && in_rng(s, i)) mdl[4][i] = '0;
                end
                2: begin
                    pkt_write(pkt_addr(s, i), d);
                    mdl_write(s, i, d);
                end
                default: begin
                    pkt_read(pkt_addr(s, i), rd, v);
                    checks++;
                    if (v !== 1'b1 || rd !== mdl_read(s, i)) begin
                        errors++;
                        $display("FAIL rnd_pkt_rd s%0d i%0d: got %h (vld %b) want %h",
                                 s, i, rd, v, mdl_read(s, i));
                    end
                end
            endcase
            @(negedge clk);
            for (int k = 0; k < int'(NR); k++) begin
                checks++;
                if (reg_key_out[k] !== mdl[1][k] || reg_mask_out[k] !== mdl[2][k] ||
                    reg_route_out[k] !== mdl[3][k][2:0]) begin
                    errors++;
                    $display("FAIL rnd_route_regs[%0d]: got %h/%h/%h want %h/%h/%h", k,
                             reg_key_out[k], reg_mask_out[k], reg_route_out[k],
                             mdl[1][k], mdl[2][k], mdl[3][k][2:0]);
                end
            end
            for (int k = 0; k < int'(NM); k++) begin
                checks++;
                if (reg_mpmsk_out[k] !== mdl[5][k] || reg_mpsft_out[k] !== mdl[6][k][4:0]) begin
                    errors++;
                    $display("FAIL rnd_map_regs[%0d]: got %h/%h want %h/%h", k,
                             reg_mpmsk_out[k], reg_mpsft_out[k], mdl[5][k], mdl[6][k][4:0]);
                end
            end
            checks++;
            if (reg_hssl_out[0] !== mdl[0][0][0]) begin
                errors++;
                $display("FAIL rnd_hssl: got %b want %b", reg_hssl_out[0], mdl[0][0][0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        apb_psel_in = 1; apb_penable_in = 0; apb_pwrite_in = 1;
        apb_paddr_in = apb_addr(1, 3); apb_pwdata_in = 32'ha5a5_a5a5;
        rsp_rdy_in = 0; prx_vld_in = 1; prx_wr_in = 0; prx_addr_in = 8'h10;
        @(posedge clk); #1;
        apb_penable_in = 1; prx_vld_in = 0;
        @(posedge clk); #3;
        reset = 1;
        #1;
        mdl_reset();
        checks++;
        if (apb_pready_out !== 1'b0 || rsp_vld_out !== 1'b0 || prx_rdy_out !== 1'b1) begin
            errors++;
            $display("FAIL midrst_async: pready=%b vld=%b rdy=%b want 0/0/1",
                     apb_pready_out, rsp_vld_out, prx_rdy_out);
        end
        apb_psel_in = 0; apb_penable_in = 0; apb_pwrite_in = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (apb_pready_out !== 1'b0 || apb_pslverr_out !== 1'b0 || apb_prdata_out !== 32'd0 ||
                rsp_vld_out !== 1'b0 || rsp_data_out !== 32'd0) begin
                errors++;
                $display("FAIL midrst_outputs cyc%0d: pready=%b err=%b prdata=%h vld=%b rsp=%h",
                         k, apb_pready_out, apb_pslverr_out, apb_prdata_out, rsp_vld_out,
                         rsp_data_out);
            end
        end
        checks++;
        if (reg_key_out !== '0 || reg_mask_out !== '0 || reg_route_out !== '0 ||
            reg_mpmsk_out !== '0 || reg_mpsft_out !== '0 || reg_hssl_out !== '0) begin
            errors++; $display("FAIL midrst_regs: register outputs not cleared");
        end
    endtask

    initial begin
        test_reset();
        test_apb_basic();
        test_apb_range();
        test_stall();
        test_back_to_back();
        test_ctr_sat();
        test_cor();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
